sm83_hram_target: RTL and testbench

SM83_HRAM_TARGET -- requirements
Module: sm83_hram_target

---
 rtl/sm83_hram_target.sv | 158 +++++++++++++++
 tb/tb_sm83_hram_target.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sm83_hram_target.sv
// sm83_hram_target: 127x8 high RAM at FF80-FFFE on the SM83 T-phase bus.
// A read is latched at the end of t1, RAM is read at the end of t3 and
// rdata is driven through t4. A write commits wdata at the end of t4.
// The end of t4 always returns the block to IDLE with outputs released.
// Optional build macro: SM83_HRAM_CHECK_EN adds a sticky bus protocol
// checker on err; without it err is tied low and no checker exists.
module sm83_hram_target (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        t1,
    input  logic        t2,
    input  logic        t3,
    input  logic        t4,
    input  logic [15:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rdata_oe,
    output logic        hit,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_WAIT = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic        hit_q, hit_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        oe_q, oe_d;
    logic [1:0]  sync_q;
    logic        ready;
    logic        addr_hit;
    logic        ram_we;
    logic [7:0]  mem [0:126];

    // Window FF80-FFFE; FFFF (IE register) belongs to someone else.
    assign addr_hit = (addr[15:7] == 9'h1FF) && (addr[6:0] != 7'h7F);
    assign ready    = sync_q[1];

    // Reset release synchroniser: two clean clocks before the FSM may start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], 1'b1};
    end

    // FSM state and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= 7'd0;
            hit_q   <= 1'b0;
            rdata_q <= 8'hFF;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            rdata_q <= rdata_d;
            oe_q    <= oe_d;
        end
    end

    // Next-state: t4 ends every M-cycle; other strobes only advance the
    // state that expects them and are otherwise ignored.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        rdata_d = rdata_q;
        oe_d    = oe_q;
        ram_we  = 1'b0;
        if (t4) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            rdata_d = 8'hFF;
            hit_d   = 1'b0;
            ram_we  = (state_q == WR_WAIT);
        end else begin
            case (state_q)
                IDLE: begin
                    if (t1 && ready) begin
                        idx_d = addr[6:0];
                        hit_d = addr_hit && (rd || wr);
                        // rd wins when both strobes are set
                        if (addr_hit && rd)      state_d = RD_ADDR;
                        else if (addr_hit && wr) state_d = WR_ADDR;
                    end
                end
                RD_ADDR: if (t2) state_d = RD_DATA;
                RD_DATA: begin
                    if (t3) begin
                        rdata_d = mem[idx_q];
                        oe_d    = 1'b1;
                    end
                end
                WR_ADDR: if (t2) state_d = WR_WAIT;
                WR_WAIT: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // RAM array: never reset; a reset before the t4 edge clears WR_WAIT
    // and so suppresses the pending write.
    always_ff @(posedge clk) begin
        if (ram_we) mem[idx_q] <= wdata;
    end

    assign rdata    = rdata_q;
    assign rdata_oe = oe_q;
    assign hit      = hit_q;

`ifdef SM83_HRAM_CHECK_EN
    logic [15:0] addr_lat_q;
    logic [1:0]  rw_prev_q;
    logic        t4_prev_q;
    logic        err_q;
    logic [3:0]  strobes;
    logic        viol;

    // Any protocol rule broken on this edge.
    always_comb begin
        strobes = {t1, t2, t3, t4};
        viol    = 1'b0;
        if ((strobes == 4'd0) || ((strobes & (strobes - 4'd1)) != 4'd0)) viol = 1'b1;
        if (t1 && rd && wr) viol = 1'b1;
        if (hit_q && t3 && (addr != addr_lat_q)) viol = 1'b1;
        if (!t4_prev_q && ({rd, wr} != rw_prev_q)) viol = 1'b1;
    end

    // Checker history and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_lat_q <= 16'd0;
            rw_prev_q  <= 2'b00;
            t4_prev_q  <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            if (t1 && !t4 && (state_q == IDLE) && ready) addr_lat_q <= addr;
            rw_prev_q <= {rd, wr};
            t4_prev_q <= t4;
            if (viol) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sm83_hram_target.sv
// Bench for sm83_hram_target: reset checks, a vector table of directed
// M-cycles, hand-written reset/addr-change sequences and random traffic
// checked against an array model of the HRAM window.
module tb_sm83_hram_target;

    logic        clk;
    logic        reset_n;
    logic        t1, t2, t3, t4;
    logic [15:0] addr;
    logic        rd, wr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rdata_oe;
    logic        hit;
    logic        err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [7:0] model_mem [0:126];

    typedef struct {
        logic        r;
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  e_rdata;
        logic        e_oe;
        logic        e_hit;
    } vec_t;

    vec_t tbl [12];

    sm83_hram_target dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .t1       (t1),
        .t2       (t2),
        .t3       (t3),
        .t4       (t4),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rdata_oe (rdata_oe),
        .hit      (hit),
        .err      (err)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic bit in_win(input logic [15:0] a);
        return (a >= 16'hFF80) && (a <= 16'hFFFE);
    endfunction

    // One full M-cycle t1..t4; entered with t1 already high.
    task automatic mcycle(input string nm, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] a_late,
                          input logic [7:0] d, input logic [7:0] e_rdata,
                          input logic e_oe, input logic e_hit);
        rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        check({nm, " hit_t2"}, {7'd0, hit}, {7'd0, e_hit});
        t1 = 1'b0; t2 = 1'b1; addr = a_late;
        @(posedge clk); #1;
        check({nm, " oe_t3"}, {7'd0, rdata_oe}, 8'd0);
        t2 = 1'b0; t3 = 1'b1;
        @(posedge clk); #1;
        check({nm, " hit_t4"}, {7'd0, hit}, {7'd0, e_hit});
        check({nm, " oe_t4"}, {7'd0, rdata_oe}, {7'd0, e_oe});
        check({nm, " rdata_t4"}, rdata, e_rdata);
        t3 = 1'b0; t4 = 1'b1;
        @(posedge clk); #1;
        check({nm, " oe_end"}, {7'd0, rdata_oe}, 8'd0);
        check({nm, " rdata_end"}, rdata, 8'hFF);
        check({nm, " hit_end"}, {7'd0, hit}, 8'd0);
        t4 = 1'b0; t1 = 1'b1; rd = 1'b0; wr = 1'b0;
    endtask

    // M-cycle whose expectations come from the array model.
    task automatic apply_model(input string nm, input logic r, input logic w,
                               input logic [15:0] a, input logic [7:0] d);
        logic       e_hit;
        logic       e_oe;
        logic [7:0] e_rdata;
        int         off;
        off     = int'(a) - 'hFF80;
        e_hit   = in_win(a) && (r || w);
        e_oe    = in_win(a) && r;
        e_rdata = e_oe ? model_mem[off] : 8'hFF;
        mcycle(nm, r, w, a, a, d, e_rdata, e_oe, e_hit);
        if (in_win(a) && w && !r) model_mem[off] = d;
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rdv;
        int          op;

        tbl[0]  = '{1'b0, 1'b1, 16'hFF80, 8'h5A, 8'hFF, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 16'hFF80, 8'h00, 8'h5A, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 16'hFFFE, 8'hC3, 8'hFF, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'hFFFE, 8'h00, 8'hC3, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 16'hFF90, 8'h11, 8'hFF, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 16'hFF90, 8'h00, 8'h11, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 16'hC000, 8'h00, 8'hFF, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 16'hFF85, 8'h33, 8'hFF, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 16'hFF85, 8'h99, 8'h33, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 16'hFF85, 8'h00, 8'h33, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 16'hFF7F, 8'hAB, 8'hFF, 1'b0, 1'b0};

        // reset
        reset_n = 1'b0;
        t1 = 1'b1; t2 = 1'b0; t3 = 1'b0; t4 = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = 16'h0000; wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset rdata", rdata, 8'hFF);
        check("reset oe", {7'd0, rdata_oe}, 8'd0);
        check("reset hit", {7'd0, hit}, 8'd0);
        check("reset err", {7'd0, err}, 8'd0);
        reset_n = 1'b1;

        // first t1 after release comes before the synchroniser settles
        mcycle("early", 1'b1, 1'b0, 16'hFF80, 16'hFF80, 8'h00, 8'hFF, 1'b0, 1'b0);
        mcycle("idle0", 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 8'hFF, 1'b0, 1'b0);
        check("err after idle", {7'd0, err}, 8'd0);

        // fill every HRAM byte so the model is fully defined
        for (int i = 0; i < 127; i++)
            apply_model("fill", 1'b0, 1'b1, 16'hFF80 + 16'(i), 8'($urandom));

        // directed vector table
        for (int i = 0; i < 12; i++) begin
            mcycle($sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].a,
                   tbl[i].d, tbl[i].e_rdata, tbl[i].e_oe, tbl[i].e_hit);
            if (in_win(tbl[i].a) && tbl[i].w && !tbl[i].r)
                model_mem[int'(tbl[i].a) - 'hFF80] = tbl[i].d;
        end

        // reset pulse inside t3 of a write: the write must not land
        apply_model("pre_rst_wr", 1'b0, 1'b1, 16'hFFA0, 8'h44);
        rd = 1'b0; wr = 1'b1; addr = 16'hFFA0; wdata = 8'h77;
        @(posedge clk); #1;
        t1 = 1'b0; t2 = 1'b1;
        @(posedge clk); #1;
        t2 = 1'b0; t3 = 1'b1;
        reset_n = 1'b0;
        #1;
        check("midrst rdata", rdata, 8'hFF);
        check("midrst oe", {7'd0, rdata_oe}, 8'd0);
        check("midrst hit", {7'd0, hit}, 8'd0);
        check("midrst err", {7'd0, err}, 8'd0);
        #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        t3 = 1'b0; t4 = 1'b1;
        @(posedge clk); #1;
        check("midrst oe_end", {7'd0, rdata_oe}, 8'd0);
        t4 = 1'b0; t1 = 1'b1; wr = 1'b0;
        apply_model("post_rst_rd", 1'b1, 1'b0, 16'hFFA0, 8'h00);

        // random traffic against the model
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) < 7) ra = 16'hFF80 + 16'($urandom_range(0, 127));
            else                          ra = 16'($urandom);
            op = $urandom_range(0, 2);
            apply_model($sformatf("rnd%0d", i), op == 1, op == 2, ra, 8'($urandom));
        end
        check("err clean traffic", {7'd0, err}, 8'd0);

        // address moves after the t1 latch: latched index still used
        rdv = model_mem[0];
        mcycle("addr_move", 1'b1, 1'b0, 16'hFF80, 16'hFF81, 8'h00, rdv, 1'b1, 1'b1);
`ifdef SM83_HRAM_CHECK_EN
        check("err addr_move", {7'd0, err}, 8'd1);
`else
        check("err addr_move", {7'd0, err}, 8'd0);
`endif
        apply_model("final_rd", 1'b1, 1'b0, 16'hFF81, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
